// File: rtl/mealy_pattern_multi.sv
// Multi-pattern serial Mealy detector. A shared bit history feeds N_PAT independent
// lanes. Each lane holds its own pattern, a non-overlap guard and a saturating hit counter.

module mealy_pattern_lane #(
  parameter int               PAT_LEN = 3,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_LEN-1:0] INIT  = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_i,
  input  logic               overlap_i,
  input  logic               filled_i,
  input  logic [PAT_LEN-1:0] win_i,
  input  logic               we_i,
  input  logic [PAT_LEN-1:0] pat_i,
  input  logic               clr_i,
  output logic               hit_o,
  output logic [CNT_W-1:0]   cnt_o
);
  localparam int GW = $clog2(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [GW-1:0]      guard_q, guard_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign hit_o = valid_i & filled_i & (win_i == pat_q) & (guard_q == '0);
  assign cnt_o = cnt_q;

  always_comb begin
    pat_d   = we_i ? pat_i : pat_q;
    guard_d = guard_q;
    if (we_i || overlap_i)               guard_d = '0;
    else if (hit_o)                      guard_d = GW'(PAT_LEN-1);
    else if (valid_i && guard_q != '0)   guard_d = guard_q - 1'b1;
    // A clear (write or cnt_clr) beats a same-cycle hit.
    cnt_d = cnt_q;
    if (we_i || clr_i)                   cnt_d = '0;
    else if (hit_o && cnt_q != '1)       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pat_q   <= INIT;
      guard_q <= '0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      guard_q <= guard_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module mealy_pattern_multi #(
  parameter int                         N_PAT    = 2,
  parameter int                         PAT_LEN  = 3,
  parameter int                         CNT_W    = 8,
  parameter logic [N_PAT*PAT_LEN-1:0]   PAT_INIT = {3'b001, 3'b110}
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i,
  input  logic                     i_valid,
  input  logic                     overlap,
  input  logic                     cfg_we,
  input  logic [$clog2(N_PAT)-1:0] cfg_sel,
  input  logic [PAT_LEN-1:0]       cfg_pat,
  input  logic                     cnt_clr,
  input  logic [$clog2(N_PAT)-1:0] cnt_sel,
  output logic [N_PAT-1:0]         o,
  output logic [CNT_W-1:0]         cnt
);
  localparam int FW = $clog2(PAT_LEN);

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PAT_LEN-1:0] win;
  logic               filled;
  logic [N_PAT-1:0][CNT_W-1:0] cnts;

  assign win    = {hist_q, i};
  assign filled = (fill_q == FW'(PAT_LEN-1));

  always_comb begin
    hist_d = i_valid ? win[PAT_LEN-2:0] : hist_q;
    fill_d = (i_valid && !filled) ? fill_q + 1'b1 : fill_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  for (genvar k = 0; k < N_PAT; k++) begin : g_lane
    // Out-of-range cfg_sel never matches any lane, so the write is dropped.
    mealy_pattern_lane #(
      .PAT_LEN (PAT_LEN),
      .CNT_W   (CNT_W),
      .INIT    (PAT_INIT[k*PAT_LEN +: PAT_LEN])
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .valid_i   (i_valid),
      .overlap_i (overlap),
      .filled_i  (filled),
      .win_i     (win),
      .we_i      (cfg_we && (int'(cfg_sel) == k)),
      .pat_i     (cfg_pat),
      .clr_i     (cnt_clr),
      .hit_o     (o[k]),
      .cnt_o     (cnts[k])
    );
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < N_PAT; k++)
      if (int'(cnt_sel) == k) cnt = cnts[k];
  end
endmodule

// File: tb/tb_mealy_pattern_multi.sv
// Bench for mealy_pattern_multi: directed vector tables plus random stimulus against
// a stream-level reference model (bit list, last-hit positions, plain counters).

module tb_mealy_pattern_multi;
  localparam int N = 2;
  localparam int L = 3;

  logic       clock = 1'b0;
  logic       reset, i, i_valid, overlap, cfg_we, cnt_clr;
  logic [0:0] cfg_sel, cnt_sel;
  logic [2:0] cfg_pat;
  logic [1:0] o, o2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  always #5 clock = ~clock;

  mealy_pattern_multi dut (
    .clock(clock), .reset(reset), .i(i), .i_valid(i_valid), .overlap(overlap),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pat(cfg_pat), .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel), .o(o), .cnt(cnt));

  mealy_pattern_multi #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .i(i), .i_valid(i_valid), .overlap(overlap),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pat(cfg_pat), .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel), .o(o2), .cnt(cnt2));

  int total = 0;
  int bad   = 0;

  // Reference model: valid bits received since reset, stream index of each
  // pattern's last guarded hit, patterns and counters.
  int         mbits[$];
  int         nbits;
  int         last_hit[N];
  logic [2:0] mpat[N];
  int         mc8[N];
  int         mc2[N];

  logic [1:0] last_o;
  logic [7:0] last_cnt;
  logic [1:0] last_cnt2;
  bit         g_ov;
  logic [0:0] g_cs;

  typedef struct {
    bit         b;
    logic [1:0] exp_o;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbits.delete();
    nbits = 0;
    mpat[0] = 3'b110;
    mpat[1] = 3'b001;
    for (int k = 0; k < N; k++) begin
      last_hit[k] = -1000;
      mc8[k] = 0;
      mc2[k] = 0;
    end
  endtask

  function automatic logic [1:0] model_o();
    logic [1:0] r;
    int w;
    r = '0;
    if (i_valid && mbits.size() >= L-1) begin
      w = mbits[mbits.size()-2]*4 + mbits[mbits.size()-1]*2 + int'(i);
      for (int k = 0; k < N; k++)
        if (w == int'(mpat[k]) && (nbits - last_hit[k]) >= L) r[k] = 1'b1;
    end
    return r;
  endfunction

  task automatic step(input bit b, input bit v, input bit ov, input bit we,
                      input logic [0:0] sel, input logic [2:0] p, input bit clr,
                      input logic [0:0] cs, input bit rst);
    logic [1:0] eo;
    i = b; i_valid = v; overlap = ov; cfg_we = we; cfg_sel = sel;
    cfg_pat = p; cnt_clr = clr; cnt_sel = cs; reset = rst;
    @(negedge clock);
    eo = model_o();
    last_o = o; last_cnt = cnt; last_cnt2 = cnt2;
    chk("o_model", o, eo);
    chk("o2_model", o2, eo);
    chk("cnt_model", cnt, mc8[cs]);
    chk("cnt2_model", cnt2, mc2[cs]);
    @(posedge clock);
    if (rst) model_reset();
    else begin
      for (int k = 0; k < N; k++) begin
        if (we && int'(sel) == k) begin
          mpat[k] = p; last_hit[k] = -1000; mc8[k] = 0; mc2[k] = 0;
        end else begin
          if (clr) begin mc8[k] = 0; mc2[k] = 0; end
          else if (eo[k]) begin
            if (mc8[k] < 255) mc8[k]++;
            if (mc2[k] < 3)   mc2[k]++;
          end
          if (ov)         last_hit[k] = -1000;
          else if (eo[k]) last_hit[k] = nbits;
        end
      end
      if (v) begin
        mbits.push_back(int'(b));
        nbits++;
        if (mbits.size() > L-1) void'(mbits.pop_front());
      end
    end
    #1;
  endtask

  task automatic sb(input bit b);
    step(b, 1'b1, g_ov, 1'b0, 1'b0, 3'b000, 1'b0, g_cs, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, g_ov, 1'b0, 1'b0, 3'b000, 1'b0, g_cs, 1'b0);
  endtask

  task automatic rst1();
    step(1'b0, 1'b0, g_ov, 1'b0, 1'b0, 3'b000, 1'b0, g_cs, 1'b1);
  endtask

  initial begin
    logic [1:0] six_ov [6];
    logic [1:0] six_no [6];
    int sat_exp [5];
    six_ov = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
    six_no = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
    sat_exp = '{1, 2, 3, 3, 3};
    tv = '{'{1'b1, 2'b00}, '{1'b1, 2'b00}, '{1'b1, 2'b00}, '{1'b0, 2'b01},
           '{1'b0, 2'b00}, '{1'b1, 2'b10}, '{1'b1, 2'b00}, '{1'b0, 2'b01},
           '{1'b0, 2'b00}, '{1'b1, 2'b10}};

    reset = 1'b1; i = 0; i_valid = 0; overlap = 0; cfg_we = 0;
    cfg_sel = 0; cfg_pat = 0; cnt_clr = 0; cnt_sel = 0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    g_ov = 1'b1; g_cs = 1'b0;
    rst1();

    // Reset state
    idle();
    chk("rst_o", last_o, 2'b00);
    chk("rst_cnt0", last_cnt, 0);
    g_cs = 1'b1; idle();
    chk("rst_cnt1", last_cnt, 0);

    // Overlapping stream 1110011001
    g_ov = 1'b1;
    foreach (tv[n]) begin
      sb(tv[n].b);
      chk($sformatf("tbl_o_bit%0d", n+1), last_o, tv[n].exp_o);
    end
    g_cs = 1'b0; idle(); chk("tbl_cnt0", last_cnt, 2);
    g_cs = 1'b1; idle(); chk("tbl_cnt1", last_cnt, 2);

    // pat1=000, six zeros, overlap then non-overlap
    for (int m = 0; m < 2; m++) begin
      g_ov = (m == 0); g_cs = 1'b1;
      rst1();
      step(1'b0, 1'b0, g_ov, 1'b1, 1'b1, 3'b000, 1'b0, g_cs, 1'b0);
      for (int n = 0; n < 6; n++) begin
        sb(1'b0);
        chk($sformatf("zeros_ov%0d_bit%0d", m, n+1), last_o, m == 0 ? six_ov[n] : six_no[n]);
      end
      idle(); chk($sformatf("zeros_ov%0d_cnt", m), last_cnt, m == 0 ? 4 : 2);
    end

    // Valid gap holds history
    g_ov = 1'b1; g_cs = 1'b0;
    rst1();
    sb(1'b1); sb(1'b1);
    for (int n = 0; n < 3; n++) begin
      idle(); chk($sformatf("gap_o%0d", n), last_o, 2'b00);
    end
    sb(1'b0); chk("gap_hit", last_o, 2'b01);

    // Counter saturation on CNT_W=2 copy, then clear beats hit
    rst1();
    for (int r = 0; r < 5; r++) begin
      sb(1'b1); sb(1'b1); sb(1'b0);
      idle(); chk($sformatf("sat_rep%0d", r+1), last_cnt2, sat_exp[r]);
    end
    sb(1'b1); sb(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("clr_hit_o", last_o, 2'b01);
    idle(); chk("clr_cnt2", last_cnt2, 0); chk("clr_cnt8", last_cnt, 0);

    // Reset mid-stream discards history
    rst1();
    sb(1'b1); sb(1'b1);
    rst1();
    sb(1'b0); chk("rstmid_o", last_o, 2'b00);
    sb(1'b1); sb(1'b1); chk("rstmid_pre", last_o, 2'b00);
    sb(1'b0); chk("rstmid_hit", last_o, 2'b01);

    // Pattern write in the cycle of a hit
    rst1();
    sb(1'b1); sb(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
    chk("cfg_old_hit", last_o, 2'b01);
    idle(); chk("cfg_cnt_clr", last_cnt, 0);
    sb(1'b1); chk("cfg_101", last_o, 2'b00);
    sb(1'b1); chk("cfg_011_hit", last_o, 2'b01);
    sb(1'b0); chk("cfg_110_miss", last_o, 2'b00);
    idle(); chk("cfg_cnt_after", last_cnt, 1);

    // Random stimulus against the model
    rst1();
    for (int n = 0; n < 3000; n++) begin
      if (n % 97 == 0) g_ov = $urandom_range(0, 1) == 1;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 8, g_ov,
           $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), $urandom_range(0, 79) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
